// File: rtl/fm_mem_pkg.sv
// Shared constants and helpers for the ping-pong feature-map RAM.
// Covers the bank-index width, the fixed read latency and address-width derivation.
package fm_mem_pkg;

    localparam int unsigned BANK_W = 1;
    localparam int unsigned RD_LAT = 2;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fm_bank_ram.sv
// Single-clock simple dual-port RAM with byte-enabled writes and a registered read.
// A read and a write to the same address on one edge return the old word.
module fm_bank_ram #(
    parameter int unsigned WR_W  = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic              clk,
    input  logic [WR_W/8-1:0] we,
    input  logic [AW-1:0]     waddr,
    input  logic [WR_W-1:0]   wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WR_W-1:0]   rdata
);

    logic [WR_W-1:0] mem_q [DEPTH];
    logic [WR_W-1:0] rdata_q;
    logic [WR_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // No reset: contents survive rst_n and the output register is qualified downstream.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WR_W / 8; b++) begin
            if (we[b]) begin
                mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fm_pingpong_ram.sv
// Double-buffered feature-map RAM: the loader fills one bank while the conv engine
// reads the other, with fill/consume handshakes and a sticky protocol-error flag.
module fm_pingpong_ram
    import fm_mem_pkg::*;
#(
    parameter int unsigned WR_W  = 32,
    parameter int unsigned RD_W  = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WA_W  = clog2(DEPTH),
    parameter int unsigned RA_W  = clog2(DEPTH * WR_W / RD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WR_W/8-1:0] wr_en,
    input  logic [WA_W-1:0]   wr_addr,
    input  logic [WR_W-1:0]   wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [RA_W-1:0]   rd_addr,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic [RD_W-1:0]   rd_data,
    output logic              rd_valid,
    output logic [1:0]        bank_full,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              err
);

    localparam int unsigned LANE_W = RA_W - WA_W;
    localparam int unsigned WR_B   = WR_W / 8;

    logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              err_q, err_d;
    logic              rd_v1_q, rd_v1_d;
    logic [BANK_W-1:0] rd_sel_q, rd_sel_d;
    logic [LANE_W-1:0] rd_lane_q, rd_lane_d;
    logic [RD_W-1:0]   rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              wr_req;
    logic              wr_ok;
    logic [WA_W-1:0]   rd_word_addr;
    logic [WR_W-1:0]   rd_word;
    logic [WR_B-1:0]   bank_we    [2];
    logic [WR_W-1:0]   bank_rdata [2];

    assign wr_ready     = ~bank_full_q[wr_bank_q];
    assign rd_ready     = bank_full_q[rd_bank_q];
    assign wr_req       = |wr_en;
    assign wr_ok        = wr_req & wr_ready;
    assign rd_word_addr = rd_addr[RA_W-1 -: WA_W];
    assign rd_word      = bank_rdata[rd_sel_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = (wr_ok && wr_bank_q == BANK_W'(b)) ? wr_en : '0;

        fm_bank_ram #(
            .WR_W  (WR_W),
            .DEPTH (DEPTH),
            .AW    (WA_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_en && rd_bank_q == BANK_W'(b)),
            .raddr (rd_word_addr),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        err_d       = err_q;

        if (wr_done) begin
            if (wr_ready) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                err_d = 1'b1;
            end
        end

        // A full bank is never the write target, so these two never touch the same bit.
        if (rd_done) begin
            if (rd_ready) begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = ~rd_bank_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if ((wr_req && !wr_ready) || (rd_en && !rd_ready)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        rd_v1_d    = rd_en & rd_ready;
        rd_sel_d   = rd_bank_q;
        rd_lane_d  = rd_addr[LANE_W-1:0];
        rd_valid_d = rd_v1_q;
        rd_data_d  = rd_data_q;
        if (rd_v1_q) begin
            rd_data_d = rd_word[rd_lane_q*RD_W +: RD_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            bank_full_q <= '0;
            err_q       <= 1'b0;
            rd_v1_q     <= 1'b0;
            rd_sel_q    <= '0;
            rd_lane_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            err_q       <= err_d;
            rd_v1_q     <= rd_v1_d;
            rd_sel_q    <= rd_sel_d;
            rd_lane_q   <= rd_lane_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bank_full = bank_full_q;
    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;
    assign err       = err_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_fm_pingpong_ram.sv
// Directed bench for fm_pingpong_ram: table-driven read streams plus hand-written
// ping-pong, protocol-error and asynchronous-reset sequences.
module tb_fm_pingpong_ram;
    import fm_mem_pkg::*;

    localparam int unsigned WR_W  = 32;
    localparam int unsigned RD_W  = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned WA_W  = 8;
    localparam int unsigned RA_W  = 10;

    typedef struct {
        logic [RA_W-1:0] addr;
        logic [RD_W-1:0] exp;
    } rd_vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        wr_en;
    logic [WA_W-1:0]   wr_addr;
    logic [WR_W-1:0]   wr_data;
    logic              wr_done;
    logic              wr_ready;
    logic              rd_en;
    logic [RA_W-1:0]   rd_addr;
    logic              rd_done;
    logic              rd_ready;
    logic [RD_W-1:0]   rd_data;
    logic              rd_valid;
    logic [1:0]        bank_full;
    logic              wr_bank;
    logic              rd_bank;
    logic              err;

    int checks   = 0;
    int failures = 0;
    rd_vec_t vecs[$];

    fm_pingpong_ram #(
        .WR_W  (WR_W),
        .RD_W  (RD_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .wr_ready  (wr_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_done   (rd_done),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .bank_full (bank_full),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_done = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        rd_done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wr(input logic [WA_W-1:0] a, input logic [31:0] d, input logic [3:0] en);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = '0;
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] base);
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    // Issues every queued read on consecutive cycles; result i appears RD_LAT edges later.
    task automatic run_reads(input string tag);
        int n;
        n = vecs.size();
        for (int i = 0; i <= n + RD_LAT - 2; i++) begin
            if (i < n) begin
                rd_en   = 1'b1;
                rd_addr = vecs[i].addr;
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (i == 0) begin
                check({tag, " first valid latency"}, 32'(rd_valid), 32'd0);
            end else if (i - 1 < n) begin
                check({tag, " valid"}, 32'(rd_valid), 32'd1);
                check({tag, " data"}, 32'(rd_data), 32'(vecs[i-1].exp));
            end
        end
        rd_en = 1'b0;
        step();
        check({tag, " valid drops"}, 32'(rd_valid), 32'd0);
        vecs.delete();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        check("reset wr_ready", 32'(wr_ready), 32'd1);
        check("reset rd_ready", 32'(rd_ready), 32'd0);
        check("reset bank_full", 32'(bank_full), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset wr_bank", 32'(wr_bank), 32'd0);
        check("reset rd_bank", 32'(rd_bank), 32'd0);
        rst_n = 1'b1;
        step();

        // rd_done and rd_en with nothing to read
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("rd_done empty err", 32'(err), 32'd1);
        check("rd_done empty rd_bank", 32'(rd_bank), 32'd0);
        check("rd_done empty bank_full", 32'(bank_full), 32'd0);
        do_reset();
        check("err cleared by reset", 32'(err), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        check("rd_en empty no valid", 32'(rd_valid), 32'd0);
        check("rd_en empty err", 32'(err), 32'd1);
        do_reset();

        // Fill bank 0
        for (int i = 0; i < 4; i++) begin
            wr(WA_W'(i), word_of(8'(4 * i)), 4'hF);
        end
        wr(8'd5, 32'h11223344, 4'hF);
        wr(8'd5, 32'hAABBCCDD, 4'b0101);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check("fill0 bank_full", 32'(bank_full), 32'h1);
        check("fill0 wr_bank", 32'(wr_bank), 32'd1);
        check("fill0 rd_ready", 32'(rd_ready), 32'd1);
        check("fill0 wr_ready", 32'(wr_ready), 32'd1);
        check("fill0 err", 32'(err), 32'd0);

        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{addr: RA_W'(i), exp: 8'(i)});
        end
        vecs.push_back('{addr: 10'd20, exp: 8'hDD});
        vecs.push_back('{addr: 10'd21, exp: 8'h33});
        vecs.push_back('{addr: 10'd22, exp: 8'hBB});
        vecs.push_back('{addr: 10'd23, exp: 8'h11});
        run_reads("bank0 stream");

        // Read bank 0 while filling bank 1, then swap both in one cycle
        for (int i = 0; i < 4; i++) begin
            wr_en   = 4'hF;
            wr_addr = WA_W'(i);
            wr_data = word_of(8'(8'h40 + 4 * i));
            rd_en   = 1'b1;
            rd_addr = RA_W'(i);
            step();
            if (i >= 1) begin
                check("pp overlap valid", 32'(rd_valid), 32'd1);
                check("pp overlap data", 32'(rd_data), 32'(i - 1));
            end
        end
        wr_en   = '0;
        rd_en   = 1'b0;
        wr_done = 1'b1;
        rd_done = 1'b1;
        step();
        wr_done = 1'b0;
        rd_done = 1'b0;
        check("pp in-flight valid", 32'(rd_valid), 32'd1);
        check("pp in-flight data", 32'(rd_data), 32'd3);
        check("pp bank_full", 32'(bank_full), 32'h2);
        check("pp wr_bank", 32'(wr_bank), 32'd0);
        check("pp rd_bank", 32'(rd_bank), 32'd1);
        check("pp rd_ready", 32'(rd_ready), 32'd1);
        check("pp err", 32'(err), 32'd0);

        vecs.push_back('{addr: 10'd0,  exp: 8'h40});
        vecs.push_back('{addr: 10'd5,  exp: 8'h45});
        vecs.push_back('{addr: 10'd10, exp: 8'h4A});
        vecs.push_back('{addr: 10'd15, exp: 8'h4F});
        vecs.push_back('{addr: 10'd3,  exp: 8'h43});
        vecs.push_back('{addr: 10'd12, exp: 8'h4C});
        run_reads("bank1 stream");

        // Both banks full, then a write that must be dropped
        wr(8'd0, 32'hDEADBEEF, 4'hF);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check("both full bank_full", 32'(bank_full), 32'h3);
        check("both full wr_ready", 32'(wr_ready), 32'd0);
        check("both full err", 32'(err), 32'd0);
        wr(8'd0, 32'h12345678, 4'hF);
        check("drop write err", 32'(err), 32'd1);
        check("drop write bank_full", 32'(bank_full), 32'h3);
        check("drop write wr_bank", 32'(wr_bank), 32'd1);
        check("drop write rd_bank", 32'(rd_bank), 32'd1);
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{addr: RA_W'(i), exp: 8'(8'h40 + i)});
        end
        run_reads("dropped write");

        // Asynchronous reset with reads in flight
        rd_en   = 1'b1;
        rd_addr = 10'd0;
        step();
        rd_addr = 10'd1;
        step();
        rd_en = 1'b0;
        check("pre-reset valid", 32'(rd_valid), 32'd1);
        check("pre-reset data", 32'(rd_data), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rd_valid", 32'(rd_valid), 32'd0);
        check("async rd_data", 32'(rd_data), 32'd0);
        check("async bank_full", 32'(bank_full), 32'd0);
        check("async err", 32'(err), 32'd0);
        check("async wr_bank", 32'(wr_bank), 32'd0);
        check("async rd_bank", 32'(rd_bank), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post-reset no valid", 32'(rd_valid), 32'd0);
        end
        check("post-reset wr_ready", 32'(wr_ready), 32'd1);
        check("post-reset err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fm_pingpong_ram.md
Name: fm_pingpong_ram

Overview:
- Parametrised, single-clock, double-buffered feature-map RAM for the conv layers.
- Successor to the per-layer conv1 feature RAM: same word-wide byte-enabled write and byte-wide read, same 2-cycle read latency.
- Adds configurable geometry and a two-bank ping-pong scheme with fill/consume handshakes, so the loader writes frame N+1 while the conv engine reads frame N.
- Sits between the feature loader (DMA side) and the conv layer PE array.

Parameters:
- WR_W, 32, write data width in bits; multiple of 8.
- RD_W, 8, read data width in bits; divides WR_W.
- DEPTH, 256, words of WR_W per bank.
- WA_W, clog2(DEPTH), write word-address width (derived).
- RA_W, clog2(DEPTH*WR_W/RD_W), read element-address width (derived).

Ports:
- clk, in, 1, single clock for both ports.
- rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, WR_W/8, per-byte write enables; any bit set = write cycle.
- wr_addr, in, WA_W, word address within current write bank.
- wr_data, in, WR_W, write data.
- wr_done, in, 1, pulse: current write bank is complete.
- wr_ready, out, 1, current write bank is empty and may be filled.
- rd_en, in, 1, read request.
- rd_addr, in, RA_W, element address within current read bank.
- rd_done, in, 1, pulse: current read bank fully consumed.
- rd_ready, out, 1, current read bank holds a complete frame.
- rd_data, out, RD_W, read data.
- rd_valid, out, 1, rd_data valid.
- bank_full, out, 2, full flag per bank.
- wr_bank, out, 1, bank currently owned by the writer.
- rd_bank, out, 1, bank currently owned by the reader.
- err, out, 1, sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): wr_bank=0, rd_bank=0, bank_full=2'b00, rd_data=0, rd_valid=0, err=0, read pipeline valids cleared. Memory contents are not cleared. Reset mid-frame discards all bank status; the next frame starts in bank 0.
- wr_ready = ~bank_full[wr_bank]; rd_ready = bank_full[rd_bank]. Both are combinational from registers.
- Write: when |wr_en and wr_ready, the enabled bytes of wr_data are written to bank wr_bank at wr_addr on the clk edge. When wr_ready=0, the write is dropped and err is set.
- wr_done with wr_ready=1: bank_full[wr_bank] is set and wr_bank toggles on the same edge. A write on the same cycle as wr_done still lands in the old bank. wr_done with wr_ready=0: ignored, err set.
- rd_done with rd_ready=1: bank_full[rd_bank] is cleared and rd_bank toggles. rd_done with rd_ready=0: ignored, err set.
- wr_done and rd_done on the same cycle: both take effect. They always target different banks because a full bank cannot be a write target and an empty bank cannot be a read target.
- Read pipeline, fixed 2-cycle latency:
  - Cycle 0: rd_en and rd_addr sampled.
  - Cycle 1: word at rd_addr[RA_W-1 : RA_W-WA_W] of bank rd_bank is registered, together with the lane select rd_addr[RA_W-WA_W-1:0] and the valid.
  - Cycle 2: lane (lane select × RD_W) is registered into rd_data; rd_valid=1.
  - Lane 0 is the least-significant RD_W bits.
- rd_en with rd_ready=0: the read is still performed, but rd_valid stays 0 for it and err is set.
- rd_done on the cycle after a read does not corrupt in-flight data. The bank index is captured at cycle 0.
- Same-bank same-address read and write on one cycle (only possible while that bank is not full): read-first, returns the old data.
- Back-to-back reads every cycle give one rd_valid per cycle.
- rd_data holds its last value when rd_valid=0.
- Address wrap: none. Addresses are exactly WA_W/RA_W bits, so every value is in range.
- err is cleared only by reset.

Decomposition:
- Shared package/header (fm_mem_pkg): bank-index width, read latency constant (RD_LAT=2), and the clog2 helper used to derive address widths.
- One natural sub-module: fm_bank_ram, a single-clock simple dual-port RAM with byte-enable write, registered read-first output, DEPTH×WR_W. It is instantiated twice, bank 0 and bank 1.
- The top module holds the bank-status registers, the ping-pong pointers, the read-side lane-select pipeline and the error logic.

Test Plan:
- Reset, then check outputs: wr_ready=1, rd_ready=0, bank_full=00, rd_valid=0, rd_data=0.
- Fill bank 0: wr_addr=0..3 with 0x03020100, 0x07060504, …, wr_en=4'hF, then wr_done. Expect bank_full=01, wr_bank=1, rd_ready=1.
- Read rd_addr=0..15 back-to-back. Expect rd_data=0x00..0x0F on consecutive cycles, first rd_valid 2 cycles after the first rd_en.
- Byte enables: write 0xAABBCCDD at word 5 with wr_en=4'b0101 over 0x11223344. Reading elements 20..23 returns DD,33,BB,11.
- Ping-pong: while reading bank 0, fill bank 1 and pulse wr_done and rd_done on the same cycle. Expect bank_full=10, wr_bank=0, rd_bank=1, and bank-1 data read correctly.
- Errors: write while both banks are full, and rd_done with rd_ready=0. Expect err=1, bank data and pointers unchanged. Then assert rst_n low mid-read: outputs return to reset values immediately (asynchronously) and the in-flight read produces no rd_valid.
